// File: rtl/verin_pio_arbiter.sv
// rtl/verin_pio_arbiter.sv - two-requester Avalon-MM arbiter in front of the actuator PIO slave
// Build option PIO_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking instead of fixed rq0 priority.
module verin_pio_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rq0_address,
    input  logic              rq0_chipselect,
    input  logic              rq0_write_n,
    input  logic [DATA_W-1:0] rq0_writedata,
    output logic [DATA_W-1:0] rq0_readdata,
    output logic              rq0_waitrequest,
    input  logic [ADDR_W-1:0] rq1_address,
    input  logic              rq1_chipselect,
    input  logic              rq1_write_n,
    input  logic [DATA_W-1:0] rq1_writedata,
    output logic [DATA_W-1:0] rq1_readdata,
    output logic              rq1_waitrequest,
    output logic [ADDR_W-1:0] pio_address,
    output logic              pio_chipselect,
    output logic              pio_write_n,
    output logic [DATA_W-1:0] pio_writedata,
    input  logic [DATA_W-1:0] pio_readdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   any_req;
    logic   pick1;
    logic   grant_now;

    assign any_req   = rq0_chipselect | rq1_chipselect;
    assign grant_now = (state == IDLE) && any_req;

`ifdef PIO_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // On a tie the requester that did not win last time goes next.
    assign pick1 = rq1_chipselect && (!rq0_chipselect || !last_grant);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_grant <= 1'b1;
        else if (grant_now)
            last_grant <= pick1;
    end
`else
    assign pick1 = rq1_chipselect && !rq0_chipselect;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req)
                    state_nxt = pick1 ? GRANT1 : GRANT0;
            end
            GRANT0:  state_nxt = IDLE;
            GRANT1:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The transfer is captured at the grant edge, so master-side changes during waitrequest are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_address    <= '0;
            pio_writedata  <= '0;
        end else if (grant_now) begin
            pio_chipselect <= 1'b1;
            pio_write_n    <= pick1 ? rq1_write_n   : rq0_write_n;
            pio_address    <= pick1 ? rq1_address   : rq0_address;
            pio_writedata  <= pick1 ? rq1_writedata : rq0_writedata;
        end else begin
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
        end
    end

    assign rq0_waitrequest = (state != GRANT0);
    assign rq1_waitrequest = (state != GRANT1);
    assign rq0_readdata    = (state == GRANT0) ? pio_readdata : '0;
    assign rq1_readdata    = (state == GRANT1) ? pio_readdata : '0;

endmodule

// File: tb/tb_verin_pio_arbiter.sv
// tb/tb_verin_pio_arbiter.sv - self-checking bench for verin_pio_arbiter against a transaction-level model
// Honours PIO_ARB_ROUND_ROBIN_EN to pick the expected tie-break rule.
module tb_verin_pio_arbiter;

`ifdef PIO_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pio_rst_n = 1'b0;
    logic [1:0]  rq0_address = '0, rq1_address = '0;
    logic        rq0_chipselect = 1'b0, rq1_chipselect = 1'b0;
    logic        rq0_write_n = 1'b1, rq1_write_n = 1'b1;
    logic [31:0] rq0_writedata = '0, rq1_writedata = '0;
    logic [31:0] rq0_readdata, rq1_readdata;
    logic        rq0_waitrequest, rq1_waitrequest;
    logic [1:0]  pio_address;
    logic        pio_chipselect, pio_write_n;
    logic [31:0] pio_writedata, pio_readdata;
    logic [7:0]  out_port;

    int n_checks = 0;
    int n_fail = 0;

    // Transaction-level reference: who is being served, the captured transfer, the PIO register.
    int          m_cur = -1;
    int          m_last = 1;
    logic [1:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic        m_wn = 1'b1;
    logic [7:0]  exp_out = '0;

    always #5 clk = ~clk;

    verin_pio_arbiter dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rq0_address     (rq0_address),
        .rq0_chipselect  (rq0_chipselect),
        .rq0_write_n     (rq0_write_n),
        .rq0_writedata   (rq0_writedata),
        .rq0_readdata    (rq0_readdata),
        .rq0_waitrequest (rq0_waitrequest),
        .rq1_address     (rq1_address),
        .rq1_chipselect  (rq1_chipselect),
        .rq1_write_n     (rq1_write_n),
        .rq1_writedata   (rq1_writedata),
        .rq1_readdata    (rq1_readdata),
        .rq1_waitrequest (rq1_waitrequest),
        .pio_address     (pio_address),
        .pio_chipselect  (pio_chipselect),
        .pio_write_n     (pio_write_n),
        .pio_writedata   (pio_writedata),
        .pio_readdata    (pio_readdata)
    );

    // Actuator PIO: 8-bit output register at address 0, combinational readdata.
    always_ff @(posedge clk or negedge pio_rst_n) begin
        if (!pio_rst_n)
            out_port <= 8'h00;
        else if (pio_chipselect && !pio_write_n && pio_address == 2'd0)
            out_port <= pio_writedata[7:0];
    end
    assign pio_readdata = (pio_address == 2'd0) ? {24'h0, out_port} : 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [31:0] rd;
        rd = (m_addr == 2'd0) ? {24'h0, exp_out} : 32'h0;
        check("rq0_wait",  32'(rq0_waitrequest), 32'(m_cur != 0));
        check("rq1_wait",  32'(rq1_waitrequest), 32'(m_cur != 1));
        check("pio_cs",    32'(pio_chipselect),  32'(m_cur != -1));
        check("pio_wn",    32'(pio_write_n),     32'(m_wn));
        check("pio_addr",  32'(pio_address),     32'(m_addr));
        check("pio_wdata", pio_writedata,        m_data);
        check("rq0_rdata", rq0_readdata,         (m_cur == 0) ? rd : 32'h0);
        check("rq1_rdata", rq1_readdata,         (m_cur == 1) ? rd : 32'h0);
        check("out_port",  32'(out_port),        32'(exp_out));
    endtask

    task automatic drive(input logic c0, input logic wn0, input logic [1:0] a0, input logic [31:0] d0,
                         input logic c1, input logic wn1, input logic [1:0] a1, input logic [31:0] d1);
        rq0_chipselect = c0; rq0_write_n = wn0; rq0_address = a0; rq0_writedata = d0;
        rq1_chipselect = c1; rq1_write_n = wn1; rq1_address = a1; rq1_writedata = d1;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 1'b1, 2'd0, 32'h0);
    endtask

    task automatic model_reset();
        m_cur = -1; m_last = 1; m_addr = '0; m_data = '0; m_wn = 1'b1;
    endtask

    // One clock: advance the model from the inputs present at the edge, then compare.
    task automatic tick();
        int w;
        @(posedge clk);
        if (m_cur != -1) begin
            if (!m_wn && m_addr == 2'd0)
                exp_out = m_data[7:0];
            m_cur = -1;
            m_wn = 1'b1;
        end else if (rq0_chipselect || rq1_chipselect) begin
            if (rq0_chipselect && rq1_chipselect)
                w = RR ? ((m_last == 1) ? 0 : 1) : 0;
            else
                w = rq1_chipselect ? 1 : 0;
            m_cur = w;
            m_last = w;
            m_addr = w ? rq1_address : rq0_address;
            m_data = w ? rq1_writedata : rq0_writedata;
            m_wn = w ? rq1_write_n : rq0_write_n;
        end
        #1;
        check_all();
    endtask

    task automatic full_reset();
        reset_n = 1'b0;
        pio_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        pio_rst_n = 1'b1;
        model_reset();
        exp_out = 8'h00;
        check_all();
    endtask

    initial begin
        int c0;
        int c1;
        drive_idle();
        full_reset();

        // Tie: rq0 first in both builds, rq1 keeps asking and follows.
        drive(1'b1, 1'b0, 2'd0, 32'h11, 1'b1, 1'b0, 2'd0, 32'h22);
        tick();
        check("tie_first_rq0", 32'(rq0_waitrequest), 32'h0);
        drive(1'b0, 1'b1, 2'd0, 32'h0, 1'b1, 1'b0, 2'd0, 32'h22);
        tick();
        check("tie_out_11", 32'(out_port), 32'h11);
        tick();
        check("tie_second_rq1", 32'(rq1_waitrequest), 32'h0);
        drive_idle();
        tick();
        check("tie_out_22", 32'(out_port), 32'h22);

        // Single write from rq0.
        drive(1'b1, 1'b0, 2'd0, 32'hA5, 1'b0, 1'b1, 2'd0, 32'h0);
        tick();
        check("wr_cs", 32'(pio_chipselect), 32'h1);
        check("wr_rq1_wait", 32'(rq1_waitrequest), 32'h1);
        drive_idle();
        tick();
        check("wr_out_a5", 32'(out_port), 32'hA5);

        // Read back through rq1.
        drive(1'b1, 1'b0, 2'd0, 32'h3C, 1'b0, 1'b1, 2'd0, 32'h0);
        tick();
        drive_idle();
        tick();
        drive(1'b0, 1'b1, 2'd0, 32'h0, 1'b1, 1'b1, 2'd0, 32'h0);
        tick();
        check("rd_addr0", rq1_readdata, 32'h3C);
        drive_idle();
        tick();
        drive(1'b0, 1'b1, 2'd0, 32'h0, 1'b1, 1'b1, 2'd1, 32'h0);
        tick();
        check("rd_addr1", rq1_readdata, 32'h0);
        drive_idle();
        tick();

        // Contention for 20 cycles.
        c0 = 0;
        c1 = 0;
        drive(1'b1, 1'b0, 2'd1, 32'hAA, 1'b1, 1'b0, 2'd1, 32'hBB);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!rq0_waitrequest) c0++;
            if (!rq1_waitrequest) c1++;
        end
        check("cont_rq0", 32'(c0), RR ? 32'd5 : 32'd10);
        check("cont_rq1", 32'(c1), RR ? 32'd5 : 32'd0);
        drive_idle();
        tick();

        // Reset mid-grant aborts a pending write of 0xFF.
        full_reset();
        drive(1'b0, 1'b1, 2'd0, 32'h0, 1'b1, 1'b0, 2'd0, 32'hFF);
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_cs_drop", 32'(pio_chipselect), 32'h0);
        check("rst_rq1_wait", 32'(rq1_waitrequest), 32'h1);
        drive_idle();
        @(posedge clk);
        #1;
        check("rst_no_write", 32'(out_port), 32'h00);
        reset_n = 1'b1;
        model_reset();
        check_all();
        drive(1'b1, 1'b0, 2'd0, 32'h5A, 1'b0, 1'b1, 2'd0, 32'h0);
        tick();
        drive_idle();
        tick();
        check("post_rst_wr", 32'(out_port), 32'h5A);

        // Random traffic, including masters changing signals while held off.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
            tick();
        end
        drive_idle();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
